// File: rtl/vga_scroll_pkg.sv
// Shared enums for the two-axis scrolling pattern engine.
package vga_scroll_pkg;

   typedef enum logic [1:0] {
      PAUSE    = 2'b00,
      CONSTANT = 2'b01,
      BOUNCE   = 2'b10,
      HOME     = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      STRIPES  = 2'b00,
      CHECKER  = 2'b01,
      GRADIENT = 2'b10,
      SOLID    = 2'b11
   } pattern_t;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_t;

endpackage

// File: rtl/scroll_axis.sv
// One scroll axis: signed speed with bounce FSM plus wrapping offset accumulator,
// all state advancing only on the frame tick.
module scroll_axis
   import vga_scroll_pkg::*;
#(
   parameter int COORD_W = 10,
   parameter int SPEED_W = 8,
   parameter int MAX     = 20,
   parameter int MIN     = -10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      tick,
   input  mode_t                     mode,
   output logic [COORD_W-1:0]        offset_o,
   output logic signed [SPEED_W-1:0] speed_o
);

   localparam logic signed [SPEED_W-1:0] MAX_S = SPEED_W'(MAX);
   localparam logic signed [SPEED_W-1:0] MIN_S = SPEED_W'(MIN);
   localparam logic signed [SPEED_W-1:0] ONE   = SPEED_W'(1);

   dir_t                      dir_q, dir_d;
   logic signed [SPEED_W-1:0] spd_q, spd_d;
   logic [COORD_W-1:0]        off_q, off_d;
   logic [COORD_W-1:0]        spd_ext;

   assign spd_ext = COORD_W'(spd_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_q <= UP;
         spd_q <= '0;
         off_q <= '0;
      end else begin
         dir_q <= dir_d;
         spd_q <= spd_d;
         off_q <= off_d;
      end
   end

   always_comb begin
      dir_d = dir_q;
      spd_d = spd_q;
      off_d = off_q;
      if (tick) begin
         case (mode)
            PAUSE: ;
            CONSTANT: off_d = off_q + spd_ext;
            BOUNCE: begin
               off_d = off_q + spd_ext;
               // Out-of-range speeds walk back toward the legal window first.
               if (spd_q > MAX_S) begin
                  spd_d = spd_q - ONE;
                  dir_d = DOWN;
               end else if (spd_q < MIN_S) begin
                  spd_d = spd_q + ONE;
                  dir_d = UP;
               end else if (dir_q == UP) begin
                  if (spd_q == MAX_S) begin
                     dir_d = DOWN;
                     spd_d = MAX_S - ONE;
                  end else begin
                     spd_d = spd_q + ONE;
                  end
               end else begin
                  if (spd_q == MIN_S) begin
                     dir_d = UP;
                     spd_d = MIN_S + ONE;
                  end else begin
                     spd_d = spd_q - ONE;
                  end
               end
            end
            HOME: begin
               off_d = '0;
               spd_d = '0;
               dir_d = UP;
            end
            default: ;
         endcase
      end
   end

   assign offset_o = off_q;
   assign speed_o  = spd_q;

endmodule

// File: rtl/vga_scroll_engine.sv
// Two-axis scrolling pattern engine: vsync edge detect, per-axis scroll state,
// pattern mux and registered colour/sync outputs.
module vga_scroll_engine
   import vga_scroll_pkg::*;
#(
   parameter int COORD_W = 10,
   parameter int SPEED_W = 8,
   parameter int X_MAX   = 20,
   parameter int X_MIN   = -10,
   parameter int Y_MAX   = 4,
   parameter int Y_MIN   = -4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      hsync,
   input  logic                      vsync,
   input  logic                      display_on,
   input  logic [COORD_W-1:0]        pix_x,
   input  logic [COORD_W-1:0]        pix_y,
   input  logic [1:0]                mode,
   input  logic [1:0]                pattern_sel,
   output logic [1:0]                R,
   output logic [1:0]                G,
   output logic [1:0]                B,
   output logic                      hsync_o,
   output logic                      vsync_o,
   output logic                      frame_tick,
   output logic [COORD_W-1:0]        offset_x,
   output logic [COORD_W-1:0]        offset_y,
   output logic signed [SPEED_W-1:0] speed_x,
   output logic signed [SPEED_W-1:0] speed_y
);

   logic               vsync_q, hsync_q;
   logic [1:0]         r_q, g_q, b_q;
   logic [1:0]         r_d, g_d, b_d;
   logic [COORD_W-1:0] mx, my;
   logic               pix_unused;
   mode_t              mode_e;
   pattern_t           pat_e;

   assign mode_e = mode_t'(mode);
   assign pat_e  = pattern_t'(pattern_sel);

   // vsync_q doubles as the delayed vsync output; resetting it high blocks a
   // tick when reset releases with vsync already asserted.
   assign frame_tick = vsync & ~vsync_q;

   scroll_axis #(
      .COORD_W (COORD_W),
      .SPEED_W (SPEED_W),
      .MAX     (X_MAX),
      .MIN     (X_MIN)
   ) u_axis_x (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (frame_tick),
      .mode     (mode_e),
      .offset_o (offset_x),
      .speed_o  (speed_x)
   );

   scroll_axis #(
      .COORD_W (COORD_W),
      .SPEED_W (SPEED_W),
      .MAX     (Y_MAX),
      .MIN     (Y_MIN)
   ) u_axis_y (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (frame_tick),
      .mode     (mode_e),
      .offset_o (offset_y),
      .speed_o  (speed_y)
   );

   assign mx         = pix_x + offset_x;
   assign my         = pix_y + offset_y;
   assign pix_unused = ^{mx, my};

   always_comb begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
      if (display_on) begin
         case (pat_e)
            STRIPES: begin
               r_d = {mx[5], my[2]};
               g_d = {mx[6], my[2]};
               b_d = {mx[7], my[5]};
            end
            CHECKER: begin
               r_d = {2{mx[5] ^ my[5]}};
               g_d = {2{mx[5] ^ my[5]}};
               b_d = {2{mx[5] ^ my[5]}};
            end
            GRADIENT: begin
               r_d = mx[7:6];
               g_d = my[7:6];
               b_d = {mx[8] ^ my[8], 1'b0};
            end
            SOLID: begin
               r_d = 2'b01;
               g_d = 2'b01;
               b_d = 2'b01;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q <= 1'b1;
         hsync_q <= 1'b1;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
      end else begin
         vsync_q <= vsync;
         hsync_q <= hsync;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
      end
   end

   assign R       = r_q;
   assign G       = g_q;
   assign B       = b_q;
   assign hsync_o = hsync_q;
   assign vsync_o = vsync_q;

endmodule

// File: tb/tb_vga_scroll_engine.sv
// Directed bench for vga_scroll_engine with hand-computed expectations.
module tb_vga_scroll_engine;

   logic              clk, rst_n, hsync, vsync, display_on;
   logic [9:0]        pix_x, pix_y;
   logic [1:0]        mode, pattern_sel;
   logic [1:0]        R, G, B;
   logic              hsync_o, vsync_o, frame_tick;
   logic [9:0]        offset_x, offset_y;
   logic signed [7:0] speed_x, speed_y;

   int checks   = 0;
   int errors   = 0;
   int tick_cnt = 0;
   int t0;
   int viol;

   vga_scroll_engine #(
      .COORD_W (10),
      .SPEED_W (8),
      .X_MAX   (20),
      .X_MIN   (-10),
      .Y_MAX   (4),
      .Y_MIN   (-4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hsync       (hsync),
      .vsync       (vsync),
      .display_on  (display_on),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .mode        (mode),
      .pattern_sel (pattern_sel),
      .R           (R),
      .G           (G),
      .B           (B),
      .hsync_o     (hsync_o),
      .vsync_o     (vsync_o),
      .frame_tick  (frame_tick),
      .offset_x    (offset_x),
      .offset_y    (offset_y),
      .speed_x     (speed_x),
      .speed_y     (speed_y)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) if (frame_tick === 1'b1) tick_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick_frame();
      vsync = 1'b0;
      cyc(2);
      vsync = 1'b1;
      cyc(3);
   endtask

   task automatic pix(input logic [1:0] pat, input logic on,
                      input logic [9:0] x, input logic [9:0] y,
                      input logic [1:0] er, input logic [1:0] eg,
                      input logic [1:0] eb, input string tag);
      pattern_sel = pat;
      display_on  = on;
      pix_x       = x;
      pix_y       = y;
      cyc(1);
      check({tag, "_r"}, R, er);
      check({tag, "_g"}, G, eg);
      check({tag, "_b"}, B, eb);
   endtask

   initial begin
      rst_n = 1'b0; hsync = 1'b1; vsync = 1'b1; display_on = 1'b0;
      pix_x = '0; pix_y = '0; mode = 2'b10; pattern_sel = 2'b11;
      cyc(3);
      rst_n = 1'b1;
      cyc(4);
      check("no_tick_after_rst", tick_cnt, 0);
      check("rst_offset_x", offset_x, 0);
      check("rst_speed_x", speed_x, 0);

      repeat (3) tick_frame();
      check("pre_rst_speed_x", speed_x, 3);
      check("pre_rst_offset_x", offset_x, 3);

      hsync = 1'b0; vsync = 1'b0; display_on = 1'b1;
      cyc(1);
      check("solid_r", R, 1);
      check("hsync_dly", hsync_o, 0);
      check("vsync_dly", vsync_o, 0);

      // asynchronous reset mid-cycle
      #3 rst_n = 1'b0;
      #1;
      check("arst_r", R, 0);
      check("arst_g", G, 0);
      check("arst_b", B, 0);
      check("arst_hsync_o", hsync_o, 1);
      check("arst_vsync_o", vsync_o, 1);
      check("arst_offset_x", offset_x, 0);
      check("arst_offset_y", offset_y, 0);
      check("arst_speed_x", speed_x, 0);
      check("arst_speed_y", speed_y, 0);
      check("arst_tick", frame_tick, 0);
      hsync = 1'b1; vsync = 1'b1; display_on = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      t0 = tick_cnt;
      cyc(5);
      check("no_tick_release_vsync_high", tick_cnt - t0, 0);
      check("release_offset_x", offset_x, 0);

      mode = 2'b10;
      viol = 0;
      for (int n = 1; n <= 53; n++) begin
         tick_frame();
         if (speed_x > 20 || speed_x < -10) viol++;
         if (speed_y > 4 || speed_y < -4) viol++;
         if (n == 20) begin
            check("b20_speed_x", speed_x, 20);
            check("b20_offset_x", offset_x, 190);
            check("b20_speed_y", speed_y, 4);
            check("b20_offset_y", offset_y, 6);
         end
         if (n == 21) begin
            check("b21_speed_x", speed_x, 19);
            check("b21_offset_x", offset_x, 210);
         end
         if (n == 50) check("b50_speed_x", speed_x, -10);
         if (n == 51) check("b51_speed_x", speed_x, -9);
         if (n == 53) begin
            check("b53_speed_x", speed_x, -7);
            check("b53_speed_y", speed_y, 3);
         end
      end
      check("speed_bounds", viol, 0);

      mode = 2'b11;
      tick_frame();
      check("home_offset_x", offset_x, 0);
      check("home_offset_y", offset_y, 0);
      check("home_speed_x", speed_x, 0);
      check("home_speed_y", speed_y, 0);
      mode = 2'b10;
      tick_frame();
      check("home_b1_speed_x", speed_x, 1);
      check("home_b1_speed_y", speed_y, 1);
      repeat (6) tick_frame();
      check("b7_speed_x", speed_x, 7);
      check("b7_offset_x", offset_x, 21);
      check("b7_speed_y", speed_y, 1);
      check("b7_offset_y", offset_y, 15);

      mode = 2'b00;
      repeat (5) tick_frame();
      check("pause_speed_x", speed_x, 7);
      check("pause_offset_x", offset_x, 21);
      check("pause_speed_y", speed_y, 1);
      check("pause_offset_y", offset_y, 15);
      vsync = 1'b0;
      cyc(2);
      t0 = tick_cnt;
      vsync = 1'b1;
      cyc(60);
      check("one_tick_long_vsync", tick_cnt - t0, 1);

      mode = 2'b11;
      tick_frame();
      mode = 2'b10;
      repeat (5) tick_frame();
      mode = 2'b01;
      repeat (2) tick_frame();
      check("const_speed_x", speed_x, 5);
      check("const_offset_x", offset_x, 20);
      check("const_offset_y", offset_y, 16);
      mode = 2'b10;
      repeat (15) tick_frame();
      check("wrap_pre_speed_x", speed_x, 20);
      check("wrap_pre_offset_x", offset_x, 200);
      check("wrap_pre_speed_y", speed_y, 4);
      check("wrap_pre_offset_y", offset_y, 12);
      mode = 2'b01;
      repeat (41) tick_frame();
      check("wrap_1020_offset_x", offset_x, 1020);
      tick_frame();
      check("wrap_offset_x", offset_x, 16);
      check("wrap_speed_x", speed_x, 20);
      check("wrap_offset_y", offset_y, 180);
      check("wrap_speed_y", speed_y, 4);

      pix(2'b01, 1'b1, 10'd16, 10'd0, 2'b00, 2'b00, 2'b00, "chk_off_a");
      pix(2'b01, 1'b1, 10'd0,  10'd0, 2'b11, 2'b11, 2'b11, "chk_off_b");

      mode = 2'b11;
      tick_frame();
      pix(2'b01, 1'b1, 10'd32,  10'd0,  2'b11, 2'b11, 2'b11, "chk_x32");
      pix(2'b01, 1'b1, 10'd32,  10'd32, 2'b00, 2'b00, 2'b00, "chk_xy32");
      pix(2'b01, 1'b0, 10'd32,  10'd0,  2'b00, 2'b00, 2'b00, "chk_blank");
      pix(2'b11, 1'b1, 10'd5,   10'd9,  2'b01, 2'b01, 2'b01, "solid");
      pix(2'b00, 1'b1, 10'h020, 10'h004, 2'b11, 2'b01, 2'b00, "stripes");
      pix(2'b10, 1'b1, 10'h1C0, 10'h080, 2'b11, 2'b10, 2'b10, "gradient");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
